stb_delay_sweep: RTL
====================

# stb_delay_sweep

Equivalent-time sampling stage that sits directly downstream of the strobe generator in the measure unit. It consumes the generator's periodic strobe and measured period, then emits a delayed sampling strobe whose offset from each strobe edge steps across one period. At each offset it samples the synchronized comparator signal over N strobes and reports a (delay, hit count) result per step through a valid/ready handshake.

## Interface
Parameters:
- T_CNT_WIDTH, 32, width of period, delay and step values in clk_i cycles
- ACC_WIDTH, 16, width of the sample counter and hit counter

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  single-cycle sweep request; accepted only in IDLE
- period_i  in  T_CNT_WIDTH  strobe period in clk_i cycles, from the strobe generator
- period_rdy_i  in  1  period_i is valid (generator ready)
- stb_i  in  1  strobe from the generator, clk_i domain
- sig_i  in  1  comparator signal, asynchronous
- step_i  in  T_CNT_WIDTH  delay increment per step
- n_samples_i  in  ACC_WIDTH  strobes sampled per step
- busy_o  out  1  high in any state other than IDLE
- dly_stb_o  out  1  one-cycle delayed sampling strobe
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result
- res_delay_o  out  T_CNT_WIDTH  delay of the reported step
- res_hits_o  out  ACC_WIDTH  count of samples with sig = 1
- done_o  out  1  one-cycle pulse at sweep completion
- err_o  out  1  sticky error
- err_code_o  out  2  1 = bad parameters, 2 = strobe timeout, 3 = strobe overrun

## Operation
- States: IDLE, ARM, DELAY, REPORT.
- **IDLE, start_i high:**
  - Clear err_o and err_code_o.
  - If period_rdy_i = 0, period_i = 0, step_i = 0 or n_samples_i = 0: set err_o, err_code = 1, stay in IDLE.
  - Otherwise latch period, step and n_samples, set delay = 0, clear hits and sample count, go to ARM.
- **ARM:** wait for a stb_i rising edge (stb_i & ~stb_prev).
  - On an edge, clear the delay counter and go to DELAY.
  - A watchdog counts ARM cycles. When it reaches 2·period (computed at T_CNT_WIDTH+1 bits), set err_o, err_code = 2, go to IDLE.
- **DELAY:** the counter increments each cycle. When counter == delay:
  - dly_stb_o = 1.
  - hits += sig_synced; sample count += 1.
  - If sample count == n_samples, go to REPORT; else go to ARM.
  - A stb_i rising edge during DELAY, before the sampling cycle, sets err_o, err_code = 3, and goes to IDLE.
- **REPORT:**
  - res_valid_o = 1; res_delay_o and res_hits_o are held stable.
  - stb_i edges are ignored.
  - On res_valid_o & res_ready_i: next = delay + step, computed at T_CNT_WIDTH+1 bits.
  - If next ≥ period: pulse done_o and go to IDLE.
  - Else: delay = next, clear hits and sample count, go to ARM.
- start_i outside IDLE is ignored. Parameter inputs are read only at start acceptance.
- The 2-stage synchronizer latency on sig_i is not compensated. Software subtracts it.

## Timing
- Reset values:
  - state IDLE.
  - All outputs 0, including err_code_o.
  - res_delay_o and res_hits_o are 0.
  - Internal counters are 0.
- Start latency: busy_o rises the cycle after start_i is sampled.
- The edge is detected in cycle k, where stb_i = 1 and it was 0 in cycle k−1. The counter is 0 in cycle k+1, and dly_stb_o is high in cycle k+1+delay. delay = 0 therefore gives dly_stb_o at k+1.
- REPORT entry: res_valid_o rises the cycle after the last sampling cycle.
- Handshake:
  - Transfer occurs on any cycle with res_valid_o & res_ready_i.
  - res_valid_o falls the next cycle.
  - With res_ready_i held high, valid lasts exactly 1 cycle.
- done_o is high in the cycle after the final transfer, coincident with busy_o falling.
- Hit counter cannot overflow because hits ≤ n_samples ≤ 2^ACC_WIDTH − 1.
- Reset mid-operation (any state) returns to IDLE immediately. Any pending result is discarded.
- A stb_i edge in the same cycle as the DELAY sampling cycle is not an overrun: sampling wins, and the edge is not re-used for ARM.

## Structure
- Package stb_sweep_pkg holds:
  - the state enum (sweep_state_t);
  - the error code constants ERR_NONE/ERR_PARAM/ERR_TIMEOUT/ERR_OVERRUN.
- Sub-module: reuse the existing sync_ff (WIDTH 1, STAGES 2) for sig_i.
- Remaining logic stays in one always_ff block (nonblocking assignments) plus combinational next-delay compare.
- Target size is about 200 lines.

## Test plan
- **Nominal sweep:** period_i = 100, step_i = 25, n_samples_i = 4, stb_i edge every 100 cycles, sig_i = 1 → four results (0,4), (25,4), (50,4), (75,4); done_o after the 4th transfer; err_o = 0.
- **Delay latency and backpressure:**
  - delay = 0: dly_stb_o exactly 1 cycle after the edge cycle.
  - res_ready_i low for 10 cycles: res_valid_o and data stay stable; stb edges are ignored; the sweep resumes after the transfer.
- **Timeout:** start accepted, then stb_i held low, period_i = 100 → err_code_o = 2 after 200 ARM cycles; busy_o = 0.
- **Overrun:** period_i = 100, step_i = 50, stb edges every 10 cycles → at delay 50, err_code_o = 3; IDLE.
- **Bad parameters and recovery:**
  - start_i with period_rdy_i = 0 → err_code_o = 1, busy_o stays 0.
  - A valid start_i next clears err_o.
- **Reset and pattern check:**
  - arst_i pulsed during DELAY → all outputs 0 in the same cycle, IDLE, no result.
  - sig_i alternating per strobe, n = 8 → hits = 4.

Source files
------------

// File: rtl/stb_sweep_pkg.sv
// Shared types and constants for the equivalent-time delay sweep stage.
package stb_sweep_pkg;

   // Sweep controller states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      DELAY  = 2'd2,
      REPORT = 2'd3
   } sweep_state_t;

   // Error codes reported on err_code_o.
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_PARAM   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for asynchronous inputs.
module sync_ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   // Shift the input through the synchronizer chain.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= {WIDTH{1'b0}};
         end
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/stb_delay_sweep.sv
// Equivalent-time sampling stage: steps a delayed sampling strobe across one
// strobe period, counts comparator hits per step and reports each step.
module stb_delay_sweep
   import stb_sweep_pkg::*;
#(
   parameter int T_CNT_WIDTH = 32,
   parameter int ACC_WIDTH   = 16
) (
   input  logic                   clk_i,
   input  logic                   arst_i,
   input  logic                   start_i,
   input  logic [T_CNT_WIDTH-1:0] period_i,
   input  logic                   period_rdy_i,
   input  logic                   stb_i,
   input  logic                   sig_i,
   input  logic [T_CNT_WIDTH-1:0] step_i,
   input  logic [ACC_WIDTH-1:0]   n_samples_i,
   output logic                   busy_o,
   output logic                   dly_stb_o,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [T_CNT_WIDTH-1:0] res_delay_o,
   output logic [ACC_WIDTH-1:0]   res_hits_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [1:0]             err_code_o
);

   sweep_state_t state, state_next;

   logic                   stb_prev;
   logic                   sig_sync;
   logic [T_CNT_WIDTH-1:0] period;
   logic [T_CNT_WIDTH-1:0] step;
   logic [T_CNT_WIDTH-1:0] delay;
   logic [T_CNT_WIDTH-1:0] dly_cnt;
   logic [T_CNT_WIDTH:0]   wd_cnt;
   logic [ACC_WIDTH-1:0]   n_samples;
   logic [ACC_WIDTH-1:0]   sample_cnt;
   logic [ACC_WIDTH-1:0]   hits;
   logic                   res_valid;
   logic                   dly_stb;
   logic                   done;
   logic                   busy;
   logic                   err;
   logic [1:0]             err_code;

   logic                   stb_edge;
   logic                   sample_now;
   logic                   last_sample;
   logic                   wd_expire;
   logic                   xfer;
   logic                   param_ok;
   logic                   sweep_end;
   logic                   dly_stb_set;
   logic [T_CNT_WIDTH:0]   delay_next;

   sync_ff #(
      .WIDTH  (1),
      .STAGES (2)
   ) u_sig_sync (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .d      (sig_i),
      .q      (sig_sync)
   );

   assign stb_edge    = stb_i & ~stb_prev;
   assign sample_now  = (state == DELAY) && (dly_cnt == delay);
   assign last_sample = ((sample_cnt + ACC_WIDTH'(1)) == n_samples);
   // Watchdog limit is twice the period; the extra bit keeps the doubling exact.
   assign wd_expire   = ((wd_cnt + (T_CNT_WIDTH+1)'(1)) >= {period, 1'b0});
   assign xfer        = res_valid & res_ready_i;
   assign param_ok    = period_rdy_i && (period_i != {T_CNT_WIDTH{1'b0}}) &&
                        (step_i != {T_CNT_WIDTH{1'b0}}) &&
                        (n_samples_i != {ACC_WIDTH{1'b0}});
   // Next delay computed one bit wider so delay + step cannot wrap below period.
   assign delay_next  = {1'b0, delay} + {1'b0, step};
   assign sweep_end   = (delay_next >= {1'b0, period});

   // Raise the delayed strobe in the cycle the counter will equal the delay.
   assign dly_stb_set = ((state == ARM) && stb_edge && (delay == {T_CNT_WIDTH{1'b0}})) ||
                        ((state == DELAY) && !sample_now && !stb_edge &&
                         ((dly_cnt + T_CNT_WIDTH'(1)) == delay));

   // Next-state decode of the sweep controller.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_i && param_ok) begin
               state_next = ARM;
            end else begin
               state_next = IDLE;
            end
         end
         ARM: begin
            if (stb_edge) begin
               state_next = DELAY;
            end else if (wd_expire) begin
               state_next = IDLE;
            end else begin
               state_next = ARM;
            end
         end
         DELAY: begin
            if (sample_now) begin
               if (last_sample) begin
                  state_next = REPORT;
               end else begin
                  state_next = ARM;
               end
            end else if (stb_edge) begin
               state_next = IDLE;
            end else begin
               state_next = DELAY;
            end
         end
         REPORT: begin
            if (xfer) begin
               if (sweep_end) begin
                  state_next = IDLE;
               end else begin
                  state_next = ARM;
               end
            end else begin
               state_next = REPORT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath: parameters, counters, result and status registers.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         stb_prev   <= 1'b0;
         period     <= {T_CNT_WIDTH{1'b0}};
         step       <= {T_CNT_WIDTH{1'b0}};
         delay      <= {T_CNT_WIDTH{1'b0}};
         dly_cnt    <= {T_CNT_WIDTH{1'b0}};
         wd_cnt     <= {(T_CNT_WIDTH+1){1'b0}};
         n_samples  <= {ACC_WIDTH{1'b0}};
         sample_cnt <= {ACC_WIDTH{1'b0}};
         hits       <= {ACC_WIDTH{1'b0}};
         res_valid  <= 1'b0;
         dly_stb    <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         stb_prev <= stb_i;
         dly_stb  <= dly_stb_set;
         done     <= 1'b0;
         busy     <= (state_next != IDLE);
         case (state)
            IDLE: begin
               if (start_i) begin
                  err      <= 1'b0;
                  err_code <= ERR_NONE;
                  if (param_ok) begin
                     period     <= period_i;
                     step       <= step_i;
                     n_samples  <= n_samples_i;
                     delay      <= {T_CNT_WIDTH{1'b0}};
                     hits       <= {ACC_WIDTH{1'b0}};
                     sample_cnt <= {ACC_WIDTH{1'b0}};
                     wd_cnt     <= {(T_CNT_WIDTH+1){1'b0}};
                  end else begin
                     err      <= 1'b1;
                     err_code <= ERR_PARAM;
                  end
               end
            end
            ARM: begin
               if (stb_edge) begin
                  dly_cnt <= {T_CNT_WIDTH{1'b0}};
               end else if (wd_expire) begin
                  err      <= 1'b1;
                  err_code <= ERR_TIMEOUT;
               end else begin
                  wd_cnt <= wd_cnt + (T_CNT_WIDTH+1)'(1);
               end
            end
            DELAY: begin
               // Sampling wins over a coincident strobe edge.
               if (sample_now) begin
                  hits       <= hits + {{(ACC_WIDTH-1){1'b0}}, sig_sync};
                  sample_cnt <= sample_cnt + ACC_WIDTH'(1);
                  wd_cnt     <= {(T_CNT_WIDTH+1){1'b0}};
                  if (last_sample) begin
                     res_valid <= 1'b1;
                  end
               end else if (stb_edge) begin
                  err      <= 1'b1;
                  err_code <= ERR_OVERRUN;
               end else begin
                  dly_cnt <= dly_cnt + T_CNT_WIDTH'(1);
               end
            end
            REPORT: begin
               if (xfer) begin
                  res_valid <= 1'b0;
                  if (sweep_end) begin
                     done <= 1'b1;
                  end else begin
                     delay      <= delay_next[T_CNT_WIDTH-1:0];
                     hits       <= {ACC_WIDTH{1'b0}};
                     sample_cnt <= {ACC_WIDTH{1'b0}};
                     wd_cnt     <= {(T_CNT_WIDTH+1){1'b0}};
                  end
               end
            end
            default: begin
               res_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy;
   assign dly_stb_o   = dly_stb;
   assign res_valid_o = res_valid;
   assign res_delay_o = delay;
   assign res_hits_o  = hits;
   assign done_o      = done;
   assign err_o       = err;
   assign err_code_o  = err_code;

endmodule
